// File: rtl/gpp16_pkg.sv
// Shared definitions for the gpp16 core: opcode values, instruction field
// layout and the fetch-stage state encoding.
package gpp16_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_MUL = 5'd2,
        OP_HLT = 5'd31
    } opcode_e;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [1:0] unused;
    } instr_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] word);
        instr_t f;
        f = instr_t'(word);
        return f.opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/ins_fetch.sv
// Instruction fetch stage: walks the PC through external memory, holds one
// fetched word under a valid/ready handshake, and stops after delivering HLT.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | fetching; a new word is captured whenever the output slot frees
// HALT  | HLT captured; PC parked on the HLT address until a redirect
module ins_fetch
    import gpp16_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic                halted
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              advance;

    assign imem_addr = pc;
    assign halted    = (state == HALT);
    assign advance   = (state == RUN) && (!out_valid || out_ready);

    // Redirect wins over everything, including a transfer in the same cycle:
    // the word on the outputs belongs to the abandoned path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (redirect_valid) begin
            state     <= RUN;
            pc        <= redirect_pc;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            if (is_hlt(imem_instr)) begin
                state <= HALT;
            end else begin
                pc <= pc + 16'd1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed program walk-through followed by random
// handshake/redirect traffic checked against a transaction-level model.
module tb_ins_fetch;
    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;

    logic [15:0] mem [0:65535];

    int vectors     = 0;
    int miscompares = 0;

    ins_fetch #(.RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc, input logic [15:0] ins);
        chk({tag, " valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, " pc"}, out_pc, pc);
        chk({tag, " instr"}, out_instr, ins);
    endtask

    task automatic redirect_to(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run_to_halt(input string tag, input logic [15:0] start);
        chk_out({tag, " w0"}, start, mem[start]);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_out({tag, " w"}, start + 16'(i), mem[start + 16'(i)]);
        end
        tick();
        chk({tag, " halted"}, {15'd0, halted}, 16'd1);
        chk({tag, " valid clr"}, {15'd0, out_valid}, 16'd0);
        chk({tag, " addr park"}, imem_addr, 16'd3);
    endtask

    // Transaction-level reference: the stream of (pc, word) pairs that must
    // cross the handshake, restarting on redirect and ending after HLT.
    logic [15:0] exp_pc;
    logic        exp_done;
    int          transfers;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[0] = 16'h0298;
        mem[1] = 16'h0C28;
        mem[2] = 16'h1524;
        mem[3] = 16'hF800;
        mem[7] = 16'h0C28;
        mem[16'hFFFF] = 16'h0C28;

        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;

        #2;
        chk("rst valid", {15'd0, out_valid}, 16'd0);
        chk("rst halted", {15'd0, halted}, 16'd0);
        chk("rst addr", imem_addr, 16'h0000);
        chk("rst instr", out_instr, 16'h0000);
        chk("rst pc", out_pc, 16'h0000);

        tick();
        rst_n = 1'b1;
        tick();
        run_to_halt("boot", 16'h0000);
        tick();
        chk("boot stay halted", {15'd0, halted}, 16'd1);
        chk("boot stay addr", imem_addr, 16'd3);
        chk("boot stay valid", {15'd0, out_valid}, 16'd0);

        // resume from halt
        redirect_to(16'h0000);
        chk("resume halted", {15'd0, halted}, 16'd0);
        chk("resume valid", {15'd0, out_valid}, 16'd0);
        tick();
        run_to_halt("resume", 16'h0000);

        // stall while out_pc=1
        redirect_to(16'h0000);
        tick();
        chk_out("stall pre0", 16'd0, 16'h0298);
        tick();
        chk_out("stall pre1", 16'd1, 16'h0C28);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall hold", 16'd1, 16'h0C28);
            chk("stall addr", imem_addr, 16'd2);
        end
        out_ready = 1'b1;
        tick();
        chk_out("stall rel", 16'd2, 16'h1524);
        tick();
        chk_out("stall hlt", 16'd3, 16'hF800);
        tick();
        chk("stall halted", {15'd0, halted}, 16'd1);

        // redirect mid-stream
        redirect_to(16'h0000);
        tick();
        chk_out("redir pre", 16'd0, 16'h0298);
        redirect_to(16'h0002);
        chk("redir flush", {15'd0, out_valid}, 16'd0);
        tick();
        chk_out("redir tgt", 16'd2, 16'h1524);

        // wrap
        redirect_to(16'hFFFF);
        tick();
        chk_out("wrap ffff", 16'hFFFF, 16'h0C28);
        tick();
        chk_out("wrap 0000", 16'h0000, 16'h0298);
        chk("wrap no halt", {15'd0, halted}, 16'd0);

        // asynchronous reset between edges with output pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst valid", {15'd0, out_valid}, 16'd0);
        chk("arst halted", {15'd0, halted}, 16'd0);
        chk("arst addr", imem_addr, 16'h0000);
        chk("arst pc", out_pc, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("arst first", 16'd0, 16'h0298);

        // random traffic
        for (int a = 256; a < 512; a++) begin
            if ($urandom_range(0, 15) == 0)
                mem[a] = {5'b11111, 11'($urandom())};
            else
                mem[a] = {5'($urandom_range(0, 30)), 11'($urandom())};
        end
        exp_pc = 16'h0000;
        exp_done = 1'b0;
        transfers = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (exp_done && cyc > 0) begin
                chk("rnd halted", {15'd0, halted}, 16'd1);
                chk("rnd idle", {15'd0, out_valid}, 16'd0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = (cyc == 0) || ($urandom_range(0, 29) == 0) ||
                             (exp_done && $urandom_range(0, 3) == 0);
            redirect_pc = 16'($urandom_range(256, 480));
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                exp_done = 1'b0;
            end else if (out_valid && out_ready) begin
                chk("rnd xfer pc", out_pc, exp_pc);
                chk("rnd xfer instr", out_instr, mem[exp_pc]);
                transfers++;
                if (mem[exp_pc][15:11] == 5'b11111) exp_done = 1'b1;
                else exp_pc = exp_pc + 16'd1;
            end
            tick();
        end
        chk("rnd progress", {15'd0, (transfers >= 500)}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
